s_array_reader: RTL and testbench
=================================

Name: s_array_reader

Overview:
Reads back the 256-entry S-array RAM after it has been filled with the identity pattern, and streams every entry out in address order over a valid/ready interface. It sits on the same single-port S-array memory as the array-initialise writer, on the read side; the top-level mux grants it the memory once the writer asserts done. An identity check (S[i]==i) runs while streaming, so the bench and the later KSA stage can confirm the fill.

Parameters:
DATA_W, 8, width of one S-array entry and of q
ADDR_W, 8, address width; array depth is 2**ADDR_W
READ_LATENCY, 1, clock cycles from address presented to q valid (legal values 1 or 2)

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; starts a full read pass when the block is idle or done
address  output  ADDR_W  S-array read address
wren  output  1  memory write enable; constant 0
q  input  DATA_W  memory read data, valid READ_LATENCY cycles after address
out_data  output  DATA_W  streamed entry S[out_index]
out_index  output  ADDR_W  address of the entry on out_data
out_valid  output  1  out_data/out_index valid
out_ready  input  1  consumer accepts the beat when out_valid && out_ready
busy  output  1  pass in progress
done  output  1  pass complete; held until the next start
mismatch  output  1  sticky; at least one entry had S[i]!=i this pass
mismatch_count  output  ADDR_W+1  number of mismatching entries this pass
first_bad_index  output  ADDR_W  index of the first mismatch; 0 if none

Behaviour:
- Async reset (reset_n=0): state IDLE, address=0, out_valid=0, out_data=0, out_index=0, busy=0, done=0, mismatch=0, mismatch_count=0, first_bad_index=0, output FIFO empty. Reset mid-pass aborts the pass immediately. No partial results are kept.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE/DONE: start=1 -> READ. On that edge: address=0, done=0, mismatch, mismatch_count and first_bad_index clear, FIFO flushes, and the issue counter loads 0.
  - READ: issue one read per cycle when credits>0. An issue places the issue counter on address; the counter then increments. After the issue at address 2**ADDR_W-1, go to DRAIN. The counter does not wrap into a second pass.
  - DRAIN: no issues. When all in-flight reads have landed and the FIFO is empty, go to DONE.
  - DONE: done=1, busy=0.
- busy=1 in READ and DRAIN only. start while busy is ignored.
- Read pipeline: an in-flight valid shift register of depth READ_LATENCY tracks each issue and its index. q is captured into the output FIFO exactly READ_LATENCY cycles after its issue.
- Output FIFO depth READ_LATENCY+1. Credit counter = FIFO depth - occupancy - in-flight reads. No issue when credits==0. The FIFO therefore never overflows under any out_ready pattern. Entries are never dropped or duplicated.
- out_valid = FIFO non-empty; out_data and out_index come from the FIFO head. A beat transfers on out_valid && out_ready. out_data/out_index hold stable while out_valid=1 and out_ready=0.
- With out_ready held 1 and READ_LATENCY=1: first beat at cycle start+2, one beat per cycle, 256 beats total, done asserts 1 cycle after the last beat.
- Identity check is evaluated when an entry is accepted on the output. On a mismatch, mismatch_count increments and mismatch sets. first_bad_index is written only on the first mismatch of the pass. The count saturates at 2**ADDR_W.
- Simultaneous FIFO push and pop in the same cycle: occupancy is unchanged.

Optional Feature:
CHECK_IDENTITY_EN: when defined, the identity check logic is built as described. When undefined, the check logic is not built and mismatch, mismatch_count and first_bad_index are tied to 0. Streaming and handshake behaviour are identical in both builds.

Test Plan:
- RAM model preloaded S[i]=i, READ_LATENCY=1, out_ready=1, start pulse -> 256 beats with out_index 0..255 and out_data==out_index, one per cycle; done=1; mismatch=0; mismatch_count=0; wren 0 throughout.
- RAM with S[0x10]=0xAA and S[0x80]=0x00 -> mismatch=1, mismatch_count=2, first_bad_index=0x10; all 256 beats still delivered in order.
- Random out_ready (30% high), READ_LATENCY=2 -> exactly 256 beats, in order, no gaps in index, data stable while stalled; address never runs more than 3 reads ahead of accepted beats.
- reset_n low at beat 100 -> all outputs at reset values asynchronously; a fresh start re-reads from address 0 with counters cleared.
- start pulsed during READ at index 50 -> ignored; the single pass completes with 256 beats. start in DONE -> second full pass, done drops the cycle after start.
- Build without CHECK_IDENTITY_EN and corrupted RAM -> mismatch outputs stay 0; stream identical to the with-check build.

Source files
------------

// File: rtl/s_array_reader_if.sv
// Signal bundle between s_array_reader, the S-array memory read port and the
// downstream stream consumer.
//
// Stream handshake: a beat (out_data, out_index) transfers on a rising clk
// edge where out_valid && out_ready are both 1. Once out_valid is 1 it stays
// 1, with out_data/out_index unchanged, until that beat transfers.
// out_valid never depends on out_ready.
interface s_array_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] address;
  logic              wren;
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              mismatch;
  logic [ADDR_W:0]   mismatch_count;
  logic [ADDR_W-1:0] first_bad_index;

  // Reader side
  modport master (
    input  start, q, out_ready,
    output address, wren, out_data, out_index, out_valid,
           busy, done, mismatch, mismatch_count, first_bad_index
  );

  // Memory model / consumer / controller side
  modport slave (
    output start, q, out_ready,
    input  address, wren, out_data, out_index, out_valid,
           busy, done, mismatch, mismatch_count, first_bad_index
  );
endinterface

// File: rtl/s_array_reader.sv
// s_array_reader: streams the 256-entry S-array out in address order over a
// valid/ready interface, checking S[i]==i on every accepted beat.
// Optional build macro CHECK_IDENTITY_EN: when defined the identity check is
// built; otherwise mismatch, mismatch_count and first_bad_index are tied to 0.
// Reads are credit-limited so the small output FIFO can never overflow,
// whatever the consumer does with out_ready.
module s_array_reader #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int READ_LATENCY = 1   // 1 or 2
) (
  input  logic             clk,
  input  logic             reset_n,
  s_array_reader_if.master bus,
  output logic [1:0]       dbg_state
);
  localparam int DEPTH = READ_LATENCY + 1;
  localparam logic [1:0]        LAST_PTR  = 2'(DEPTH - 1);
  localparam logic [2:0]        DEPTH_3   = 3'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
  state_t state, state_nxt;

  logic [ADDR_W:0]         issue_cnt;                 // next address to read
  logic [READ_LATENCY-1:0] fl_vld;                    // reads in flight
  logic [ADDR_W-1:0]       fl_idx [READ_LATENCY];     // their addresses
  logic [DATA_W-1:0]       fifo_data [4];             // only DEPTH entries used
  logic [ADDR_W-1:0]       fifo_idx  [4];
  logic [1:0]              rd_ptr, wr_ptr, occ, inflight;
  logic                    start_acc, issue, push, pop, credit_ok, out_valid_int;
  logic [DATA_W-1:0]       head_data;
  logic [ADDR_W-1:0]       head_idx;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

  assign start_acc     = bus.start && (state == IDLE || state == DONE);
  assign push          = fl_vld[READ_LATENCY-1];
  assign out_valid_int = (occ != 2'd0);
  assign pop           = out_valid_int && bus.out_ready;
  assign head_data     = fifo_data[rd_ptr];
  assign head_idx      = fifo_idx[rd_ptr];

  // Count outstanding reads still travelling through the memory pipeline
  always_comb begin
    inflight = 2'd0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + {1'b0, fl_vld[i]};
  end

  // A slot freed by this cycle's pop is reusable at once, which keeps one read per cycle
  assign credit_ok = ({1'b0, occ} + {1'b0, inflight}) < (DEPTH_3 + {2'b00, pop});
  assign issue     = (state == READ) && !issue_cnt[ADDR_W] && credit_ok;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nxt = READ;
      READ:       if (issue && issue_cnt[ADDR_W-1:0] == LAST_ADDR) state_nxt = DRAIN;
      DRAIN:      if (inflight == 2'd0 && occ == 2'd0) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Issue counter and in-flight tracking of each read and its index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_cnt <= '0;
      fl_vld    <= '0;
      for (int i = 0; i < READ_LATENCY; i++) fl_idx[i] <= '0;
    end else begin
      if (start_acc)  issue_cnt <= '0;
      else if (issue) issue_cnt <= issue_cnt + CNT_ONE;
      fl_vld[0] <= issue;
      fl_idx[0] <= issue_cnt[ADDR_W-1:0];
      for (int i = 1; i < READ_LATENCY; i++) begin
        fl_vld[i] <= fl_vld[i-1];
        fl_idx[i] <= fl_idx[i-1];
      end
    end
  end

  // Output FIFO: captures q as each read lands, drains on accepted beats
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      occ    <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_data[i] <= '0;
        fifo_idx[i]  <= '0;
      end
    end else if (start_acc) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= bus.q;
        fifo_idx[wr_ptr]  <= fl_idx[READ_LATENCY-1];
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef CHECK_IDENTITY_EN
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  logic              mm_flag;
  logic [ADDR_W:0]   mm_cnt;
  logic [ADDR_W-1:0] mm_first;
  logic              entry_bad;

  assign entry_bad = pop && (head_data != DATA_W'(head_idx));

  // Identity check on each accepted beat; first bad index latched once per pass
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mm_flag  <= 1'b0;
      mm_cnt   <= '0;
      mm_first <= '0;
    end else if (start_acc) begin
      mm_flag  <= 1'b0;
      mm_cnt   <= '0;
      mm_first <= '0;
    end else if (entry_bad) begin
      mm_flag <= 1'b1;
      if (!mm_flag) mm_first <= head_idx;
      if (mm_cnt != CNT_MAX) mm_cnt <= mm_cnt + CNT_ONE;
    end
  end

  assign bus.mismatch        = mm_flag;
  assign bus.mismatch_count  = mm_cnt;
  assign bus.first_bad_index = mm_first;
`else
  assign bus.mismatch        = 1'b0;
  assign bus.mismatch_count  = '0;
  assign bus.first_bad_index = '0;
`endif

  assign bus.address   = issue_cnt[ADDR_W-1:0];
  assign bus.wren      = 1'b0;
  assign bus.out_valid = out_valid_int;
  assign bus.out_data  = head_data;
  assign bus.out_index = head_idx;
  assign bus.busy      = (state == READ) || (state == DRAIN);
  assign bus.done      = (state == DONE);
  assign dbg_state     = state;
endmodule

// File: tb/tb_s_array_reader.sv
// Bench for s_array_reader: two instances (read latency 1 and 2) share one
// RAM image and the same start/out_ready/reset_n stimulus. Each beat is
// scored against the expected stream {i, S[i]} for i = 0..255.
module tb_s_array_reader;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int N      = 1 << ADDR_W;
  localparam int BEAT_W = ADDR_W + DATA_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  int   ready_pct = 100;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   start_cyc = 0;

  logic [DATA_W-1:0] ram [N];
  logic [DATA_W-1:0] q2_pipe;
  logic [1:0]        dbg_state1, dbg_state2;

  s_array_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();
  s_array_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus2 ();

  assign bus1.start     = start;
  assign bus1.out_ready = out_ready;
  assign bus2.start     = start;
  assign bus2.out_ready = out_ready;

  s_array_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .dbg_state(dbg_state1));
  s_array_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LATENCY(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .dbg_state(dbg_state2));

  // ---------------- clock / reset / memory models ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus1.q <= ram[bus1.address];
  always @(posedge clk) begin
    q2_pipe <= ram[bus2.address];
    bus2.q  <= q2_pipe;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [BEAT_W-1:0] exp_q0[$];
  logic [BEAT_W-1:0] exp_q1[$];
  int  beats [2];
  int  first_cyc [2];
  int  last_cyc [2];
  int  done_cyc [2];
  int  max_lead [2];
  bit  wren_seen [2];
  bit  stalled [2];
  logic [BEAT_W-1:0] held [2];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic reset_stats();
    for (int g = 0; g < 2; g++) begin
      beats[g] = 0; first_cyc[g] = -1; last_cyc[g] = -1; done_cyc[g] = -1;
      max_lead[g] = 0; wren_seen[g] = 1'b0; stalled[g] = 1'b0; held[g] = '0;
    end
  endtask

  task automatic load_expected();
    exp_q0.delete();
    exp_q1.delete();
    for (int i = 0; i < N; i++) begin
      exp_q0.push_back({ADDR_W'(i), ram[i]});
      exp_q1.push_back({ADDR_W'(i), ram[i]});
    end
  endtask

  task automatic observe(input int g, input logic v, input logic [ADDR_W-1:0] idx,
                         input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] addr,
                         input logic bsy, input logic dn, input logic wr);
    logic [BEAT_W-1:0] e;
    bit have;
    int lead;
    e = '0;
    have = 1'b0;
    if (wr) wren_seen[g] = 1'b1;
    if (stalled[g]) begin
      check_eq($sformatf("stall_valid_lat%0d", g + 1), 32'(v), 32'd1);
      check_eq($sformatf("stall_hold_lat%0d", g + 1), 32'({idx, d}), 32'(held[g]));
    end
    lead = int'(addr) - beats[g];
    if (bsy && lead > max_lead[g]) max_lead[g] = lead;
    if (dn && done_cyc[g] < 0) done_cyc[g] = cyc;
    if (v && out_ready) begin
      if (g == 0) begin
        have = (exp_q0.size() != 0);
        if (have) e = exp_q0.pop_front();
      end else begin
        have = (exp_q1.size() != 0);
        if (have) e = exp_q1.pop_front();
      end
      check_eq($sformatf("beat_expected_lat%0d", g + 1), 32'(have), 32'd1);
      if (have)
        check_eq($sformatf("beat%0d_lat%0d", beats[g], g + 1), 32'({idx, d}), 32'(e));
      if (beats[g] == 0) first_cyc[g] = cyc;
      last_cyc[g] = cyc;
      beats[g]++;
    end
    stalled[g] = v && !out_ready;
    held[g]    = {idx, d};
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      observe(0, bus1.out_valid, bus1.out_index, bus1.out_data, bus1.address,
              bus1.busy, bus1.done, bus1.wren);
      observe(1, bus2.out_valid, bus2.out_index, bus2.out_data, bus2.address,
              bus2.busy, bus2.done, bus2.wren);
    end
  end

  // ---------------- driver tasks ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
    end
  end

  task automatic fill_identity();
    for (int i = 0; i < N; i++) ram[i] = DATA_W'(i);
  endtask

  task automatic pulse_start(input bit expect_accept);
    @(posedge clk);
    #1;
    if (expect_accept) load_expected();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (expect_accept) begin
      start_cyc = cyc;
      reset_stats();
      check_eq("done_drop_lat1", 32'(bus1.done), 32'd0);
      check_eq("done_drop_lat2", 32'(bus2.done), 32'd0);
      check_eq("busy_rise_lat1", 32'(bus1.busy), 32'd1);
      check_eq("busy_rise_lat2", 32'(bus2.busy), 32'd1);
    end
  endtask

  task automatic wait_beats(input int n);
    int k;
    k = 0;
    while (beats[0] < n && k < 5000) begin
      @(posedge clk);
      k++;
    end
    check_eq("beats_within_budget", 32'(beats[0] >= n), 32'd1);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!(bus1.done && bus2.done) && k < 5000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq("done_within_budget", 32'(bus1.done && bus2.done), 32'd1);
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check_eq("rst_address1", 32'(bus1.address), 0);
    check_eq("rst_address2", 32'(bus2.address), 0);
    check_eq("rst_valid",    32'({bus1.out_valid, bus2.out_valid}), 0);
    check_eq("rst_data",     32'({bus1.out_data, bus2.out_data}), 0);
    check_eq("rst_index",    32'({bus1.out_index, bus2.out_index}), 0);
    check_eq("rst_busy",     32'({bus1.busy, bus2.busy}), 0);
    check_eq("rst_done",     32'({bus1.done, bus2.done}), 0);
    check_eq("rst_mismatch", 32'({bus1.mismatch, bus2.mismatch}), 0);
    check_eq("rst_mm_count", 32'({bus1.mismatch_count, bus2.mismatch_count}), 0);
    check_eq("rst_first_bad", 32'({bus1.first_bad_index, bus2.first_bad_index}), 0);
    check_eq("rst_wren",     32'({bus1.wren, bus2.wren}), 0);
  endtask

  // Count entries with S[i] != i straight from the RAM image
  task automatic expected_identity(output int cnt, output int first);
    cnt = 0;
    first = 0;
    for (int i = 0; i < N; i++) begin
      if (ram[i] != DATA_W'(i)) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
  endtask

  task automatic end_pass(input string name, input bit full_rate);
    int cnt, first, exp_mm, exp_cnt, exp_first;
    expected_identity(cnt, first);
`ifdef CHECK_IDENTITY_EN
    exp_mm = (cnt != 0) ? 1 : 0;
    exp_cnt = cnt;
    exp_first = first;
`else
    exp_mm = 0;
    exp_cnt = 0;
    exp_first = 0;
`endif
    check_eq({name, "_beats_lat1"}, 32'(beats[0]), 32'(N));
    check_eq({name, "_beats_lat2"}, 32'(beats[1]), 32'(N));
    check_eq({name, "_leftover"}, 32'(exp_q0.size() + exp_q1.size()), 0);
    check_eq({name, "_wren"}, 32'(wren_seen[0] | wren_seen[1]), 0);
    check_eq({name, "_lead_lat1"}, 32'(max_lead[0] <= 2), 32'd1);
    check_eq({name, "_lead_lat2"}, 32'(max_lead[1] <= 3), 32'd1);
    check_eq({name, "_done_after_last1"}, 32'(done_cyc[0] - last_cyc[0]), 32'd2);
    check_eq({name, "_done_after_last2"}, 32'(done_cyc[1] - last_cyc[1]), 32'd2);
    check_eq({name, "_busy_end"}, 32'({bus1.busy, bus2.busy}), 0);
    check_eq({name, "_done_end"}, 32'({bus1.done, bus2.done}), 32'b11);
    check_eq({name, "_mismatch1"}, 32'(bus1.mismatch), 32'(exp_mm));
    check_eq({name, "_mismatch2"}, 32'(bus2.mismatch), 32'(exp_mm));
    check_eq({name, "_mm_count1"}, 32'(bus1.mismatch_count), 32'(exp_cnt));
    check_eq({name, "_mm_count2"}, 32'(bus2.mismatch_count), 32'(exp_cnt));
    check_eq({name, "_first_bad1"}, 32'(bus1.first_bad_index), 32'(exp_first));
    check_eq({name, "_first_bad2"}, 32'(bus2.first_bad_index), 32'(exp_first));
    if (full_rate) begin
      check_eq({name, "_first_beat1"}, 32'(first_cyc[0] - start_cyc), 32'd2);
      check_eq({name, "_first_beat2"}, 32'(first_cyc[1] - start_cyc), 32'd3);
      check_eq({name, "_back_to_back1"}, 32'(last_cyc[0] - first_cyc[0]), 32'(N - 1));
      check_eq({name, "_back_to_back2"}, 32'(last_cyc[1] - first_cyc[1]), 32'(N - 1));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    fill_identity();
    reset_stats();
    #2;
    check_reset_values();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle_busy", 32'({bus1.busy, bus2.busy}), 0);
    check_eq("idle_valid", 32'({bus1.out_valid, bus2.out_valid}), 0);

    // Identity RAM, consumer always ready
    ready_pct = 100;
    pulse_start(1'b1);
    wait_done();
    end_pass("identity", 1'b1);

    // Two corrupted entries, restarted from DONE
    ram[8'h10] = 8'hAA;
    ram[8'h80] = 8'h00;
    pulse_start(1'b1);
    wait_done();
    end_pass("two_bad", 1'b1);

    // Random corruption, 30% ready, start pulsed mid-pass must be ignored
    fill_identity();
    repeat (4) ram[$urandom_range(0, N - 1)] = DATA_W'($urandom);
    ready_pct = 30;
    pulse_start(1'b1);
    wait_beats(50);
    pulse_start(1'b0);
    wait_done();
    end_pass("random_stall", 1'b0);

    // Every entry wrong: count reaches its 256 ceiling, first bad is index 0
    for (int i = 0; i < N; i++) ram[i] = DATA_W'(i) ^ 8'hFF;
    ready_pct = 100;
    pulse_start(1'b1);
    wait_done();
    end_pass("all_bad", 1'b1);

    // Asynchronous reset part-way through a pass
    fill_identity();
    ram[8'h05] = 8'h77;
    ready_pct = 60;
    pulse_start(1'b1);
    wait_beats(100);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_values();
    exp_q0.delete();
    exp_q1.delete();
    reset_stats();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Fresh pass after reset re-reads from address 0 with counters cleared
    fill_identity();
    ready_pct = 50;
    pulse_start(1'b1);
    wait_done();
    end_pass("after_reset", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
